wb_arbiter: RTL and testbench
=============================

# wb_arbiter

Parametrised writeback arbiter between the execution-side result producers (ALU, 5-stage multiplier, data cache, and future units) and the integer register-file write port. Each source pushes results into its own small FIFO through a valid/ready handshake. Every cycle one pending result is selected and registered onto the write port, so a result is never dropped when several units complete in the same cycle.

## Interface
Parameters:
- NUM_SRC, 3: number of result sources (2..8).
- DATA_W, 32: write-data, instruction and PC width.
- ADDR_W, 5: register address width.
- DEPTH, 2: entries per source FIFO (power of two, 2..8).

Derived values:
- SRC_W = max(1, clog2(NUM_SRC)).
- CNT_W = clog2(DEPTH)+1.

Ports. The clock is `clk_i`. Reset is `rsn_i`, asynchronous and active-low.
- clk_i, in, 1: clock; all state updates on the rising edge.
- rsn_i, in, 1: asynchronous active-low reset.
- src_valid_i, in, NUM_SRC: source i offers a result.
- src_ready_o, out, NUM_SRC: FIFO i can accept a result.
- src_data_i, in, NUM_SRC*DATA_W: write data; source i occupies slice [i*DATA_W +: DATA_W].
- src_addr_i, in, NUM_SRC*ADDR_W: destination register addresses.
- src_instr_i, in, NUM_SRC*DATA_W: instruction words.
- src_pc_i, in, NUM_SRC*DATA_W: instruction PCs.
- write_int_write_enable_o, out, 1: register-file write strobe.
- write_int_write_data_o, out, DATA_W: write data.
- write_write_addr_o, out, ADDR_W: destination address.
- write_instruction_o, out, DATA_W: instruction of the written result.
- write_pc_o, out, DATA_W: PC of the written result.
- write_src_o, out, SRC_W: index of the source that won the write.
- pending_o, out, NUM_SRC*CNT_W: per-source FIFO occupancy.

## Operation
- **FIFOs:** one FIFO per source, each DEPTH entries wide enough for data, addr, instr and pc. Read and write pointers wrap modulo DEPTH; a separate count register tracks occupancy.
- **Ready:** src_ready_o[i] = (count_i < DEPTH), computed from registered count only. A full FIFO never accepts a push, even in a cycle where it pops.
- **Push:** on a rising edge with src_valid_i[i] && src_ready_o[i], write the entry at the FIFO i write pointer.
- **Requests:** req[i] = (count_i != 0). The grant is combinational from req and the arbitration state.
- **Default arbitration:** fixed priority; the lowest index wins.
- **Pop and register:** the winner's head entry pops on the rising edge. In the same edge the entry loads all write_* outputs, write_src_o is set to the winner index, and write_int_write_enable_o is set to 1.
- **Idle cycle:** when no request is present, write_int_write_enable_o is 0. Data, addr, instr, pc and src hold their previous values.
- **Simultaneous push and pop** on the same FIFO (not full): count is unchanged and both pointers advance.
- **Back-pressure:** a source must hold its valid and payload stable until ready is seen. Dropping valid without a handshake is permitted; nothing is captured in that case.
- **Ordering:** entries from the same source always leave in order. There is no ordering guarantee across sources.

## Timing
- **Reset** (asynchronous; takes effect immediately while rsn_i is low):
  - all counts and pointers are 0;
  - all write_* outputs, write_src_o and pending_o are 0;
  - src_ready_o is all ones;
  - the round-robin pointer is NUM_SRC-1.
- **Latency:** a result accepted at edge N with all other FIFOs empty appears on write_* after edge N+1, so the minimum latency is 2 edges from valid to write strobe.
- **Throughput:** one writeback per cycle in total. Each source sustains one result per cycle only while it wins every cycle.
- **Reset mid-operation:** all pending entries are discarded. The first write after rsn_i rises requires a new push.

## Configuration
- **WB_RR_ARB_EN defined:** round-robin arbitration.
  - Search starts at (rr_ptr+1) mod NUM_SRC.
  - rr_ptr updates to the winner index on each grant and holds when there is no grant.
  - No source waits more than NUM_SRC-1 grants while it has a pending entry.
- **WB_RR_ARB_EN not defined:** fixed priority with index 0 highest. rr_ptr is not implemented.

## Test plan
- **Reset state:** hold rsn_i=0 for 3 cycles with random inputs. Required: enable=0, all outputs 0, src_ready_o=3'b111. Assert rsn_i low mid-burst and confirm outputs clear asynchronously, before the next edge.
- **Single source:** one push on source 1 with data=0xDEADBEEF, addr=7, pc=0x100. Required two edges later: enable=1 for exactly one cycle, data=0xDEADBEEF, addr=7, write_src_o=1.
- **Three-way collision, fixed priority:** push on sources 0, 1 and 2 in the same cycle. Required: writes on 3 consecutive cycles in order 0, 1, 2, with none lost.
- **Back-pressure on a full FIFO:** hold source 2 valid for 6 cycles while source 0 pushes every cycle. Required: pending for source 2 reaches 2, src_ready_o[2]=0, and all of source 2's results retire in order once source 0 stops.
- **Round-robin (WB_RR_ARB_EN):** all 3 sources are continuously valid. Required grant sequence after reset: 0, 1, 2, 0, 1, 2.
- **Pointer wrap:** issue DEPTH*3 pushes on source 0 with the output free every cycle. Required: data emerges in push order across pointer wrap, and count never exceeds DEPTH.

Source files
------------

// File: rtl/wb_arbiter.sv
// wb_arbiter: per-source result FIFOs merged onto one register-file write port.
// Define WB_RR_ARB_EN for round-robin arbitration; the default is fixed priority.
module wb_arbiter #(
    parameter int NUM_SRC = 3,
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 5,
    parameter int DEPTH   = 2,
    localparam int SRC_W  = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1,
    localparam int CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic                      clk_i,
    input  logic                      rsn_i,
    input  logic [NUM_SRC-1:0]        src_valid_i,
    output logic [NUM_SRC-1:0]        src_ready_o,
    input  logic [NUM_SRC*DATA_W-1:0] src_data_i,
    input  logic [NUM_SRC*ADDR_W-1:0] src_addr_i,
    input  logic [NUM_SRC*DATA_W-1:0] src_instr_i,
    input  logic [NUM_SRC*DATA_W-1:0] src_pc_i,
    output logic                      write_int_write_enable_o,
    output logic [DATA_W-1:0]         write_int_write_data_o,
    output logic [ADDR_W-1:0]         write_write_addr_o,
    output logic [DATA_W-1:0]         write_instruction_o,
    output logic [DATA_W-1:0]         write_pc_o,
    output logic [SRC_W-1:0]          write_src_o,
    output logic [NUM_SRC*CNT_W-1:0]  pending_o
);

    localparam int PTR_W = $clog2(DEPTH);

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] instr;
        logic [DATA_W-1:0] pc;
    } entry_t;

    entry_t             mem_q    [NUM_SRC][DEPTH];
    entry_t             in_ent   [NUM_SRC];
    logic [CNT_W-1:0]   count_q  [NUM_SRC];
    logic [PTR_W-1:0]   rd_ptr_q [NUM_SRC];
    logic [PTR_W-1:0]   wr_ptr_q [NUM_SRC];
    logic [NUM_SRC-1:0] ready;
    logic [NUM_SRC-1:0] req;
    logic [NUM_SRC-1:0] push;
    logic [NUM_SRC-1:0] pop;
    logic               grant_vld;
    logic [SRC_W-1:0]   grant_idx;
    entry_t             head;

    // Unpack each source's flat payload slice into a FIFO entry
    always_comb begin
        for (int i = 0; i < NUM_SRC; i++) begin
            in_ent[i].data  = src_data_i[i*DATA_W +: DATA_W];
            in_ent[i].addr  = src_addr_i[i*ADDR_W +: ADDR_W];
            in_ent[i].instr = src_instr_i[i*DATA_W +: DATA_W];
            in_ent[i].pc    = src_pc_i[i*DATA_W +: DATA_W];
        end
    end

    // Ready, request and push qualify off the registered occupancy only
    always_comb begin
        ready     = '0;
        req       = '0;
        push      = '0;
        pending_o = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            ready[i] = count_q[i] < CNT_W'(DEPTH);
            req[i]   = count_q[i] != '0;
            push[i]  = src_valid_i[i] & ready[i];
            pending_o[i*CNT_W +: CNT_W] = count_q[i];
        end
    end

    assign src_ready_o = ready;

`ifdef WB_RR_ARB_EN
    logic [SRC_W-1:0] rr_ptr_q;

    // Round-robin: first requester after the previous winner
    always_comb begin
        int idx;
        grant_vld = 1'b0;
        grant_idx = '0;
        idx       = 0;
        for (int k = NUM_SRC; k >= 1; k--) begin
            idx = (int'(rr_ptr_q) + k) % NUM_SRC;
            if (req[idx]) begin
                grant_vld = 1'b1;
                grant_idx = SRC_W'(idx);
            end
        end
    end

    // Remember the last winner; hold when nothing is granted
    always_ff @(posedge clk_i or negedge rsn_i) begin
        if (!rsn_i) begin
            rr_ptr_q <= SRC_W'(NUM_SRC - 1);
        end else if (grant_vld) begin
            rr_ptr_q <= grant_idx;
        end
    end
`else
    // Fixed priority: lowest index wins
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (req[i]) begin
                grant_vld = 1'b1;
                grant_idx = SRC_W'(i);
            end
        end
    end
`endif

    // One-hot pop of the winner and its head entry
    always_comb begin
        pop = '0;
        if (grant_vld) begin
            pop[grant_idx] = 1'b1;
        end
        head = mem_q[grant_idx][rd_ptr_q[grant_idx]];
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk_i or negedge rsn_i) begin
        if (!rsn_i) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                count_q[i]  <= '0;
                rd_ptr_q[i] <= '0;
                wr_ptr_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_SRC; i++) begin
                case ({push[i], pop[i]})
                    2'b10:   count_q[i] <= count_q[i] + CNT_W'(1);
                    2'b01:   count_q[i] <= count_q[i] - CNT_W'(1);
                    default: count_q[i] <= count_q[i];
                endcase
                if (push[i]) begin
                    wr_ptr_q[i] <= wr_ptr_q[i] + PTR_W'(1);
                end
                if (pop[i]) begin
                    rd_ptr_q[i] <= rd_ptr_q[i] + PTR_W'(1);
                end
            end
        end
    end

    // FIFO storage; contents are qualified by count so need no reset
    always_ff @(posedge clk_i) begin
        for (int i = 0; i < NUM_SRC; i++) begin
            if (push[i]) begin
                mem_q[i][wr_ptr_q[i]] <= in_ent[i];
            end
        end
    end

    // Register the winning entry onto the write port
    always_ff @(posedge clk_i or negedge rsn_i) begin
        if (!rsn_i) begin
            write_int_write_enable_o <= 1'b0;
            write_int_write_data_o   <= '0;
            write_write_addr_o       <= '0;
            write_instruction_o      <= '0;
            write_pc_o               <= '0;
            write_src_o              <= '0;
        end else begin
            write_int_write_enable_o <= grant_vld;
            if (grant_vld) begin
                write_int_write_data_o <= head.data;
                write_write_addr_o     <= head.addr;
                write_instruction_o    <= head.instr;
                write_pc_o             <= head.pc;
                write_src_o            <= grant_idx;
            end
        end
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: scoreboard bench for wb_arbiter.
// Expected writebacks are queued with stimulus; a negedge monitor retires them.
module tb_wb_arbiter;

    localparam int NS    = 3;
    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int DEPTH = 2;
    localparam int CW    = 2;
    localparam int SW    = 2;

    logic             clk_i = 1'b0;
    logic             rsn_i = 1'b1;
    logic [NS-1:0]    src_valid_i = '0;
    logic [NS-1:0]    src_ready_o;
    logic [NS*DW-1:0] src_data_i = '0;
    logic [NS*AW-1:0] src_addr_i = '0;
    logic [NS*DW-1:0] src_instr_i = '0;
    logic [NS*DW-1:0] src_pc_i = '0;
    logic             write_int_write_enable_o;
    logic [DW-1:0]    write_int_write_data_o;
    logic [AW-1:0]    write_write_addr_o;
    logic [DW-1:0]    write_instruction_o;
    logic [DW-1:0]    write_pc_o;
    logic [SW-1:0]    write_src_o;
    logic [NS*CW-1:0] pending_o;

    always #5 clk_i = ~clk_i;

    wb_arbiter #(
        .NUM_SRC(NS),
        .DATA_W (DW),
        .ADDR_W (AW),
        .DEPTH  (DEPTH)
    ) dut (
        .clk_i                   (clk_i),
        .rsn_i                   (rsn_i),
        .src_valid_i             (src_valid_i),
        .src_ready_o             (src_ready_o),
        .src_data_i              (src_data_i),
        .src_addr_i              (src_addr_i),
        .src_instr_i             (src_instr_i),
        .src_pc_i                (src_pc_i),
        .write_int_write_enable_o(write_int_write_enable_o),
        .write_int_write_data_o  (write_int_write_data_o),
        .write_write_addr_o      (write_write_addr_o),
        .write_instruction_o     (write_instruction_o),
        .write_pc_o              (write_pc_o),
        .write_src_o             (write_src_o),
        .pending_o               (pending_o)
    );

    typedef struct {
        logic [SW-1:0] src;
        logic [DW-1:0] data;
        logic [AW-1:0] addr;
        logic [DW-1:0] instr;
        logic [DW-1:0] pc;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   max_pend[NS];
    bit   saw_nr[NS];
    int   acc_cnt[NS];

    function automatic exp_t item(input int s, input int j);
        exp_t e;
        e.src   = SW'(s);
        e.data  = 32'hD000_0000 | 32'(s << 16) | 32'(j);
        e.addr  = AW'(s * 8 + j + 1);
        e.instr = 32'h0000_0013 | 32'(j << 20) | 32'(s << 15);
        e.pc    = 32'h0000_1000 + 32'(s * 256) + 32'(j * 4);
        return e;
    endfunction

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic drive(input int s, input exp_t e);
        src_data_i[s*DW +: DW]  = e.data;
        src_addr_i[s*AW +: AW]  = e.addr;
        src_instr_i[s*DW +: DW] = e.instr;
        src_pc_i[s*DW +: DW]    = e.pc;
    endtask

    // Scoreboard monitor: every write strobe retires the oldest expectation
    always @(negedge clk_i) begin : mon
        exp_t e;
        if (rsn_i === 1'b1 && write_int_write_enable_o === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write src=%0d data=%h required=no write",
                         write_src_o, write_int_write_data_o);
            end else begin
                e = exp_q.pop_front();
                if (write_src_o !== e.src || write_int_write_data_o !== e.data ||
                    write_write_addr_o !== e.addr ||
                    write_instruction_o !== e.instr || write_pc_o !== e.pc) begin
                    errors++;
                    $display("FAIL wb_entry actual src=%0d data=%h addr=%0d instr=%h pc=%h required src=%0d data=%h addr=%0d instr=%h pc=%h",
                             write_src_o, write_int_write_data_o, write_write_addr_o,
                             write_instruction_o, write_pc_o,
                             e.src, e.data, e.addr, e.instr, e.pc);
                end
            end
        end
    end

    task automatic do_reset(input bit check);
        rsn_i = 1'b0;
        exp_q.delete();
        repeat (3) begin
            src_valid_i = NS'($urandom);
            src_data_i  = {$urandom, $urandom, $urandom};
            src_addr_i  = (NS*AW)'($urandom);
            src_instr_i = {$urandom, $urandom, $urandom};
            src_pc_i    = {$urandom, $urandom, $urandom};
            @(negedge clk_i);
            if (check) begin
                chk("rst_enable", 64'(write_int_write_enable_o), 64'd0);
                chk("rst_data", 64'(write_int_write_data_o), 64'd0);
                chk("rst_addr", 64'(write_write_addr_o), 64'd0);
                chk("rst_instr", 64'(write_instruction_o), 64'd0);
                chk("rst_pc", 64'(write_pc_o), 64'd0);
                chk("rst_src", 64'(write_src_o), 64'd0);
                chk("rst_pending", 64'(pending_o), 64'd0);
                chk("rst_ready", 64'(src_ready_o), 64'h7);
            end
        end
        src_valid_i = '0;
        @(negedge clk_i);
        rsn_i = 1'b1;
        @(posedge clk_i);
        #1;
    endtask

    // Per-source driver: source s offers items 0..lim-1 while cycle < hold
    task automatic burst(input int l0, input int l1, input int l2,
                         input int h0, input int h1, input int h2);
        int lim[NS];
        int hold[NS];
        int idx[NS];
        int c;
        int p;
        bit done;
        logic [NS-1:0] acc;
        lim  = '{l0, l1, l2};
        hold = '{h0, h1, h2};
        for (int s = 0; s < NS; s++) begin
            idx[s]      = 0;
            max_pend[s] = 0;
            saw_nr[s]   = 1'b0;
        end
        c    = 0;
        done = 1'b0;
        while (!done && c < 40) begin
            for (int s = 0; s < NS; s++) begin
                if (idx[s] < lim[s] && c < hold[s]) begin
                    src_valid_i[s] = 1'b1;
                    drive(s, item(s, idx[s]));
                end else begin
                    src_valid_i[s] = 1'b0;
                end
                p = int'(pending_o[s*CW +: CW]);
                if (p > max_pend[s]) max_pend[s] = p;
                if (src_ready_o[s] == 1'b0) saw_nr[s] = 1'b1;
            end
            acc = src_valid_i & src_ready_o;
            @(posedge clk_i);
            for (int s = 0; s < NS; s++) begin
                if (acc[s]) idx[s]++;
            end
            #1;
            c++;
            done = 1'b1;
            for (int s = 0; s < NS; s++) begin
                if (idx[s] < lim[s] && c < hold[s]) done = 1'b0;
            end
        end
        src_valid_i = '0;
        for (int s = 0; s < NS; s++) acc_cnt[s] = idx[s];
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL burst_timeout cycles=%0d required=done", c);
        end
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 40) begin
            @(posedge clk_i);
            #1;
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_drain left=%0d required=0", name, exp_q.size());
        end
        repeat (3) @(posedge clk_i);
        #1;
    endtask

    initial begin : stim
        exp_t e;
        #1;
        do_reset(1'b1);

        // Single push on source 1
        e.src   = 2'd1;
        e.data  = 32'hDEAD_BEEF;
        e.addr  = 5'd7;
        e.instr = 32'h0000_0013;
        e.pc    = 32'h0000_0100;
        exp_q.push_back(e);
        chk("single_ready", 64'(src_ready_o[1]), 64'd1);
        src_valid_i = 3'b010;
        drive(1, e);
        @(posedge clk_i);
        #1;
        src_valid_i = '0;
        @(negedge clk_i);
        chk("single_lat_en0", 64'(write_int_write_enable_o), 64'd0);
        @(negedge clk_i);
        chk("single_en1", 64'(write_int_write_enable_o), 64'd1);
        @(negedge clk_i);
        chk("single_pulse_en0", 64'(write_int_write_enable_o), 64'd0);
        drain("single");

        // Three-way collision
        do_reset(1'b0);
        exp_q.push_back(item(0, 0));
        exp_q.push_back(item(1, 0));
        exp_q.push_back(item(2, 0));
        burst(1, 1, 1, 99, 99, 99);
        @(negedge clk_i);
        chk("coll_lat_en0", 64'(write_int_write_enable_o), 64'd0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk_i);
            chk("coll_en_run", 64'(write_int_write_enable_o), 64'd1);
        end
        @(negedge clk_i);
        chk("coll_en_end", 64'(write_int_write_enable_o), 64'd0);
        drain("collision");

        // Back-pressure: source 2 held valid 6 cycles behind source 0
        do_reset(1'b0);
`ifdef WB_RR_ARB_EN
        exp_q.push_back(item(0, 0));
        exp_q.push_back(item(2, 0));
        exp_q.push_back(item(0, 1));
        exp_q.push_back(item(2, 1));
        exp_q.push_back(item(0, 2));
        exp_q.push_back(item(2, 2));
        exp_q.push_back(item(0, 3));
        exp_q.push_back(item(2, 3));
        exp_q.push_back(item(0, 4));
        exp_q.push_back(item(0, 5));
`else
        for (int j = 0; j < 6; j++) exp_q.push_back(item(0, j));
        exp_q.push_back(item(2, 0));
        exp_q.push_back(item(2, 1));
`endif
        burst(6, 0, 99, 99, 99, 6);
        chk("bp_max_pending2", 64'(max_pend[2]), 64'd2);
        chk("bp_ready2_low", 64'(saw_nr[2]), 64'd1);
`ifdef WB_RR_ARB_EN
        chk("bp_accepted2", 64'(acc_cnt[2]), 64'd4);
`else
        chk("bp_accepted2", 64'(acc_cnt[2]), 64'd2);
`endif
        drain("backpressure");

        // All sources saturated from reset
        do_reset(1'b0);
`ifdef WB_RR_ARB_EN
        exp_q.push_back(item(0, 0));
        exp_q.push_back(item(1, 0));
        exp_q.push_back(item(2, 0));
        exp_q.push_back(item(0, 1));
        exp_q.push_back(item(1, 1));
        exp_q.push_back(item(2, 1));
`else
        exp_q.push_back(item(0, 0));
        exp_q.push_back(item(0, 1));
        exp_q.push_back(item(1, 0));
        exp_q.push_back(item(1, 1));
        exp_q.push_back(item(2, 0));
        exp_q.push_back(item(2, 1));
`endif
        burst(2, 2, 2, 99, 99, 99);
        drain("saturate");

        // Pointer wrap on source 0
        do_reset(1'b0);
        for (int j = 0; j < DEPTH * 3; j++) exp_q.push_back(item(0, j));
        burst(DEPTH * 3, 0, 0, 99, 99, 99);
        chk("wrap_count_bound", 64'(max_pend[0] <= DEPTH), 64'd1);
        drain("wrap");

        // Asynchronous reset in the middle of a burst
        do_reset(1'b0);
        exp_q.push_back(item(0, 0));
        exp_q.push_back(item(1, 0));
        exp_q.push_back(item(2, 0));
        burst(1, 1, 1, 99, 99, 99);
        @(posedge clk_i);
        @(negedge clk_i);
        chk("mid_en_before", 64'(write_int_write_enable_o), 64'd1);
        #2;
        rsn_i = 1'b0;
        #1;
        chk("async_en", 64'(write_int_write_enable_o), 64'd0);
        chk("async_data", 64'(write_int_write_data_o), 64'd0);
        chk("async_pc", 64'(write_pc_o), 64'd0);
        chk("async_pending", 64'(pending_o), 64'd0);
        chk("async_ready", 64'(src_ready_o), 64'h7);
        exp_q.delete();
        @(negedge clk_i);
        rsn_i = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk_i);
            chk("post_rst_no_write", 64'(write_int_write_enable_o), 64'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog_timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
